watch_set_controller: RTL and testbench

//  Consumes the one-clock MODE and ADJUST pulses produced by the button pulse

---
 rtl/watch_set_controller_pkg.sv | 29 ++
 rtl/watch_set_controller_idle_timer.sv | 36 +++
 rtl/watch_set_controller.sv | 114 +++++++++++
 tb/tb_watch_set_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_set_controller_pkg.sv
// Shared definitions for the watch time-setting controller: state encodings,
// default idle timeout and the MODE step sequence.
// Latency: n/a (types and functions only). Backpressure: n/a.
package watch_set_controller_pkg;

  // 2-bit encoding with all four codes used, so there is no illegal state.
  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } set_state_t;

  localparam int TIMEOUT_S_DEFAULT = 30;
  localparam int TMR_W_DEFAULT     = 6;

  // One MODE press advances NORMAL -> HOUR -> MIN -> SEC -> NORMAL.
  function automatic set_state_t next_field(input set_state_t s);
    set_state_t n;
    case (s)
      ST_NORMAL:   n = ST_SET_HOUR;
      ST_SET_HOUR: n = ST_SET_MIN;
      ST_SET_MIN:  n = ST_SET_SEC;
      default:     n = ST_NORMAL;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/watch_set_controller_idle_timer.sv
// Idle timer for the SET_* states: counts tick_1hz, flags expiry on the tick
// that completes TIMEOUT_S idle seconds. expired is combinational (same cycle
// as the tick); the caller registers it. No backpressure.
// Ports: clock, reset (async high), clear, tick_1hz, enable in; expired out.
module watch_idle_timer
  import watch_set_controller_pkg::*;
#(
  parameter int TIMEOUT_S = TIMEOUT_S_DEFAULT,
  parameter int TMR_W     = TMR_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick_1hz,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_S - 1);

  logic [TMR_W-1:0] r_cnt;

  // A pulse coincident with the final tick wins: clear masks expiry.
  assign expired = enable & tick_1hz & ~clear & (r_cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || !enable || expired) begin
      r_cnt <= '0;
    end else if (tick_1hz) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/watch_set_controller.sv
// Watch time-setting controller: steps NORMAL/SET_HOUR/SET_MIN/SET_SEC on MODE,
// issues one-cycle inc_hour/inc_min/clr_sec strobes on ADJUST, drives run_en/blink.
// Latency: every output is registered, one cycle after its cause. No backpressure.
// Ports in: clock, reset (async high), tick_1hz, mode_pulse, adjust_pulse.
// Ports out: set_state[1:0], inc_hour, inc_min, clr_sec, run_en, blink.
// Option: WATCH_SET_TIMEOUT_EN adds the idle timer that returns to NORMAL after
// TIMEOUT_S seconds without a key press; without it TIMEOUT_S/TMR_W are unused.
module watch_set_controller
  import watch_set_controller_pkg::*;
#(
  parameter int TIMEOUT_S = TIMEOUT_S_DEFAULT,
  parameter int TMR_W     = TMR_W_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       mode_pulse,
  input  logic       adjust_pulse,
  output logic [1:0] set_state,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       run_en,
  output logic       blink
);

  set_state_t r_state;
  logic       r_inc_hour, r_inc_min, r_clr_sec, r_run_en, r_blink;

  set_state_t w_next_state;
  logic       w_next_inc_hour, w_next_inc_min, w_next_clr_sec;
  logic       w_next_run_en, w_next_blink;
  logic       w_adj_eff;
  logic       w_expired;

`ifdef WATCH_SET_TIMEOUT_EN
  watch_idle_timer #(
    .TIMEOUT_S (TIMEOUT_S),
    .TMR_W     (TMR_W)
  ) u_idle_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (mode_pulse | adjust_pulse),
    .tick_1hz (tick_1hz),
    .enable   (r_state != ST_NORMAL),
    .expired  (w_expired)
  );
`else
  logic w_unused_cfg;
  assign w_expired    = 1'b0;
  assign w_unused_cfg = ^{TIMEOUT_S[0], TMR_W[0]};
`endif

  // MODE has priority; an ADJUST in the same cycle is dropped.
  assign w_adj_eff = adjust_pulse & ~mode_pulse;

  always_comb begin
    w_next_state    = r_state;
    w_next_inc_hour = 1'b0;
    w_next_inc_min  = 1'b0;
    w_next_clr_sec  = 1'b0;
    w_next_blink    = r_blink;

    if (mode_pulse) begin
      w_next_state = next_field(r_state);
    end else if (w_expired) begin
      w_next_state = ST_NORMAL;
    end

    if (w_adj_eff) begin
      case (r_state)
        ST_SET_HOUR: w_next_inc_hour = 1'b1;
        ST_SET_MIN:  w_next_inc_min  = 1'b1;
        ST_SET_SEC:  w_next_clr_sec  = 1'b1;
        default:     ;
      endcase
    end

    // Field shows solid on entry and right after an adjust so the user sees the new value.
    if (w_next_state == ST_NORMAL || w_next_state != r_state || w_adj_eff) begin
      w_next_blink = 1'b0;
    end else if (tick_1hz) begin
      w_next_blink = ~r_blink;
    end

    w_next_run_en = (w_next_state != ST_SET_SEC);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_NORMAL;
      r_inc_hour <= 1'b0;
      r_inc_min  <= 1'b0;
      r_clr_sec  <= 1'b0;
      r_run_en   <= 1'b1;
      r_blink    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_inc_hour <= w_next_inc_hour;
      r_inc_min  <= w_next_inc_min;
      r_clr_sec  <= w_next_clr_sec;
      r_run_en   <= w_next_run_en;
      r_blink    <= w_next_blink;
    end
  end

  assign set_state = r_state;
  assign inc_hour  = r_inc_hour;
  assign inc_min   = r_inc_min;
  assign clr_sec   = r_clr_sec;
  assign run_en    = r_run_en;
  assign blink     = r_blink;

endmodule

// File: tb/tb_watch_set_controller.sv
// Self-checking bench for watch_set_controller. Expected output words are pushed
// to a queue as each stimulus cycle is driven and popped after the clock edge.
// Word layout: {set_state[1:0], inc_hour, inc_min, clr_sec, run_en, blink}.
module tb_watch_set_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       mode_pulse = 1'b0;
  logic       adjust_pulse = 1'b0;
  logic [1:0] set_state;
  logic       inc_hour, inc_min, clr_sec, run_en, blink;
  logic [6:0] obs;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_q[$];

  always #5 clock = ~clock;

  watch_set_controller #(
    .TIMEOUT_S (3),
    .TMR_W     (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tick_1hz     (tick_1hz),
    .mode_pulse   (mode_pulse),
    .adjust_pulse (adjust_pulse),
    .set_state    (set_state),
    .inc_hour     (inc_hour),
    .inc_min      (inc_min),
    .clr_sec      (clr_sec),
    .run_en       (run_en),
    .blink        (blink)
  );

  assign obs = {set_state, inc_hour, inc_min, clr_sec, run_en, blink};

  // run_en is 0 exactly when the state is SET_SEC.
  function automatic logic [6:0] ex(input logic [1:0] st, input logic ih, input logic im,
                                    input logic cs, input logic bl);
    return {st, ih, im, cs, (st != 2'd3), bl};
  endfunction

  // One clock cycle with the given pulses; inputs change 1 time unit after the edge.
  task automatic cyc(input logic m, input logic a, input logic t);
    mode_pulse   = m;
    adjust_pulse = a;
    tick_1hz     = t;
    @(posedge clock);
    #1;
    mode_pulse   = 1'b0;
    adjust_pulse = 1'b0;
    tick_1hz     = 1'b0;
  endtask

  task automatic test_reset;
    logic [6:0] e;
    repeat (2) @(posedge clock);
    #1;
    exp_q.push_back(ex(2'd0, 0, 0, 0, 0));
    e = exp_q.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_init: got %b expected %b", obs, e); end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(ex(2'(i + 1), 0, 0, 0, 0));
      cyc(1, 0, 0);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL reset_enter %0d: got %b expected %b", i, obs, e); end
    end
    // Async reset while in SET_MIN with a tick pending.
    exp_q.push_back(ex(2'd0, 0, 0, 0, 0));
    tick_1hz = 1'b1;
    reset = 1'b1;
    #2;
    tick_1hz = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_async: got %b expected %b", obs, e); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.push_back(ex(2'd0, 0, 0, 0, 0));
    cyc(0, 0, 0);
    e = exp_q.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_release: got %b expected %b", obs, e); end
  endtask

  task automatic test_mode_cycle;
    logic [6:0] e;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 5; c++) begin
        exp_q.push_back(ex(2'((p + 1) % 4), 0, 0, 0, 0));
        cyc(c == 0, 0, 0);
        e = exp_q.pop_front();
        n_tests++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL mode_cycle p%0d c%0d: got %b expected %b", p, c, obs, e);
        end
      end
    end
  endtask

  task automatic test_adjust;
    logic [2:0] stim [10];
    logic [6:0] expv [10];
    logic [6:0] e;
    stim = '{3'b100, 3'b010, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b100, 3'b010, 3'b000};
    expv = '{ex(1, 0, 0, 0, 0), ex(1, 1, 0, 0, 0), ex(1, 1, 0, 0, 0), ex(1, 1, 0, 0, 0),
             ex(1, 0, 0, 0, 0), ex(2, 0, 0, 0, 0), ex(3, 0, 0, 0, 0), ex(0, 0, 0, 0, 0),
             ex(0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0)};
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(expv[i]);
      cyc(stim[i][2], stim[i][1], stim[i][0]);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL adjust step %0d: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_mode_adjust_same_cycle;
    logic [2:0] stim [6];
    logic [6:0] expv [6];
    logic [6:0] e;
    stim = '{3'b100, 3'b100, 3'b010, 3'b110, 3'b000, 3'b100};
    expv = '{ex(1, 0, 0, 0, 0), ex(2, 0, 0, 0, 0), ex(2, 0, 1, 0, 0),
             ex(3, 0, 0, 0, 0), ex(3, 0, 0, 0, 0), ex(0, 0, 0, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(expv[i]);
      cyc(stim[i][2], stim[i][1], stim[i][0]);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL same_cycle step %0d: got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_blink;
    logic [2:0] stim [13];
    logic [6:0] expv [13];
    logic [6:0] e;
    stim = '{3'b100, 3'b001, 3'b001, 3'b010, 3'b001, 3'b011, 3'b001,
             3'b101, 3'b001, 3'b100, 3'b010, 3'b100, 3'b001};
    expv = '{ex(1, 0, 0, 0, 0), ex(1, 0, 0, 0, 1), ex(1, 0, 0, 0, 0), ex(1, 1, 0, 0, 0),
             ex(1, 0, 0, 0, 1), ex(1, 1, 0, 0, 0), ex(1, 0, 0, 0, 1), ex(2, 0, 0, 0, 0),
             ex(2, 0, 0, 0, 1), ex(3, 0, 0, 0, 0), ex(3, 0, 0, 1, 0), ex(0, 0, 0, 0, 0),
             ex(0, 0, 0, 0, 0)};
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(expv[i]);
      cyc(stim[i][2], stim[i][1], stim[i][0]);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL blink step %0d: got %b expected %b", i, obs, e); end
    end
  endtask

`ifdef WATCH_SET_TIMEOUT_EN
  task automatic test_timeout;
    logic [2:0] stim [17];
    logic [6:0] expv [17];
    logic [6:0] e;
    stim = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b000,
             3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b011, 3'b001, 3'b001, 3'b001, 3'b000};
    expv = '{ex(1, 0, 0, 0, 0), ex(2, 0, 0, 0, 0), ex(3, 0, 0, 0, 0), ex(3, 0, 0, 0, 1),
             ex(3, 0, 0, 0, 0), ex(0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0),
             ex(1, 0, 0, 0, 0), ex(2, 0, 0, 0, 0), ex(3, 0, 0, 0, 0), ex(3, 0, 0, 0, 1),
             ex(3, 0, 0, 0, 0), ex(3, 0, 0, 1, 0), ex(3, 0, 0, 0, 1), ex(3, 0, 0, 0, 0),
             ex(0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0)};
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(expv[i]);
      cyc(stim[i][2], stim[i][1], stim[i][0]);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL timeout step %0d: got %b expected %b", i, obs, e); end
    end
  endtask
`else
  task automatic test_no_timeout;
    logic [6:0] e;
    logic       bl;
    exp_q.push_back(ex(1, 0, 0, 0, 0));
    cyc(1, 0, 0);
    e = exp_q.pop_front();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL hold_enter: got %b expected %b", obs, e); end
    bl = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bl = ~bl;
      exp_q.push_back(ex(1, 0, 0, 0, bl));
      exp_q.push_back(ex(1, 0, 0, 0, bl));
      cyc(0, 0, 1);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL hold_tick %0d: got %b expected %b", i, obs, e); end
      cyc(0, 0, 0);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL hold_idle %0d: got %b expected %b", i, obs, e); end
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ex(2'((i + 2) % 4), 0, 0, 0, 0));
      cyc(1, 0, 0);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL hold_exit %0d: got %b expected %b", i, obs, e); end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mode_cycle();
    test_adjust();
    test_mode_adjust_same_cycle();
    test_blink();
`ifdef WATCH_SET_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
